// File: rtl/down_counter_bout.sv
// Loadable down counter with registered one-cycle borrow-out pulse on expiry.
// Optional feature: define AUTO_RELOAD_EN to reload the last loaded value after each expiry.
module down_counter_bout #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] I,
  input  logic             CE,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      reload <= '0;
    end else if (LOAD) begin
      reload <= I;
    end
  end
`endif

  // LOAD wins over everything; a zero load skips RUN and expires straight away.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      O     <= '0;
    end else if (LOAD) begin
      O     <= I;
      state <= (I != '0) ? RUN : DONE;
    end else begin
      case (state)
        RUN: begin
          if (CE && (O != '0)) begin
            O <= O - WIDTH'(1);
            if (O == WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
`ifdef AUTO_RELOAD_EN
          O     <= reload;
          state <= (reload != '0) ? RUN : IDLE;
`else
          O     <= '0;
          state <= IDLE;
`endif
        end
        default: begin
          O     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign BOUT = (state == DONE);
  assign BUSY = (state == RUN);

endmodule
